// File: rtl/axi_read_arbiter_if.sv
// AXI read-master channel bundle (AR + R) between the arbiter and the AXI bridge.
//   master modport: drives AR fields, ARVALID and RREADY; samples ARREADY and the R channel.
//   slave  modport: the mirror image, used by the interconnect side.
interface axi_read_arbiter_if;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [1:0]        ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read master between an instruction-side (s0)
// and a data-side (s1) requester. Each requester may have one burst outstanding;
// R beats are routed back by RID, stray IDs are drained and flagged in rid_err_o.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable_i          gates new grants only
//   sN_ar*_i/_o       requester AR request and combinational grant pulse
//   sN_r*_i/_o        routed R channel toward requester N (combinational)
//   m_axi             AXI read master (registered AR, pass-through R)
//   rid_err_o         sticky unmatched-RID flag
module axi_read_arbiter #(
  parameter logic [3:0] S0_ID = 4'h0,
  parameter logic [3:0] S1_ID = 4'h1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_i,
  input  logic                s0_arvalid_i,
  output logic                s0_arready_o,
  input  logic [31:0]         s0_araddr_i,
  input  logic [7:0]          s0_arlen_i,
  input  logic [2:0]          s0_arsize_i,
  input  logic [1:0]          s0_arburst_i,
  output logic                s0_rvalid_o,
  input  logic                s0_rready_i,
  output logic [31:0]         s0_rdata_o,
  output logic [1:0]          s0_rresp_o,
  output logic                s0_rlast_o,
  input  logic                s1_arvalid_i,
  output logic                s1_arready_o,
  input  logic [31:0]         s1_araddr_i,
  input  logic [7:0]          s1_arlen_i,
  input  logic [2:0]          s1_arsize_i,
  input  logic [1:0]          s1_arburst_i,
  output logic                s1_rvalid_o,
  input  logic                s1_rready_i,
  output logic [31:0]         s1_rdata_o,
  output logic [1:0]          s1_rresp_o,
  output logic                s1_rlast_o,
  axi_read_arbiter_if.master  m_axi,
  output logic                rid_err_o
);
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic {ST_IDLE = 1'b0, ST_AR_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic              out0_q, out0_d, out1_q, out1_d;
  logic              last_grant_q, last_grant_d;
  logic              rid_err_q;

  logic elig0_c, elig1_c, grant0_c, grant1_c, ar_hs_c;
  logic match0_c, match1_c, rready_c, done0_c, done1_c;

  assign elig0_c = s0_arvalid_i & ~out0_q & enable_i;
  assign elig1_c = s1_arvalid_i & ~out1_q & enable_i;
  assign ar_hs_c = arvalid_q & m_axi.ARREADY;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: leave IDLE on any grant, return on AR handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (elig0_c | elig1_c) state_d = ST_AR_WAIT;
      ST_AR_WAIT: if (ar_hs_c)           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant decode; on a tie the requester that did not win last time wins
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == ST_IDLE) begin
      if (elig0_c & elig1_c) begin
        grant0_c = last_grant_q;
        grant1_c = ~last_grant_q;
      end else begin
        grant0_c = elig0_c;
        grant1_c = elig1_c;
      end
    end
  end

  // R routing: only an ID with an outstanding burst is considered a match
  assign match0_c = (m_axi.RID == S0_ID) & out0_q;
  assign match1_c = (m_axi.RID == S1_ID) & out1_q;
  assign rready_c = match0_c ? s0_rready_i : (match1_c ? s1_rready_i : 1'b1);
  assign done0_c  = m_axi.RVALID & rready_c & m_axi.RLAST & match0_c;
  assign done1_c  = m_axi.RVALID & rready_c & m_axi.RLAST & match1_c;

  // AR channel and bookkeeping next-state
  always_comb begin
    arvalid_d    = arvalid_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    last_grant_d = last_grant_q;
    out0_d       = out0_q & ~done0_c;
    out1_d       = out1_q & ~done1_c;
    if (grant0_c) begin
      arvalid_d    = 1'b1;
      arid_d       = S0_ID;
      araddr_d     = s0_araddr_i;
      arlen_d      = s0_arlen_i;
      arsize_d     = s0_arsize_i;
      arburst_d    = s0_arburst_i;
      last_grant_d = 1'b0;
      out0_d       = 1'b1;
    end else if (grant1_c) begin
      arvalid_d    = 1'b1;
      arid_d       = S1_ID;
      araddr_d     = s1_araddr_i;
      arlen_d      = s1_arlen_i;
      arsize_d     = s1_arsize_i;
      arburst_d    = s1_arburst_i;
      last_grant_d = 1'b1;
      out1_d       = 1'b1;
    end else if (ar_hs_c) begin
      arvalid_d = 1'b0;
      arid_d    = '0;
      araddr_d  = '0;
      arlen_d   = '0;
      arsize_d  = '0;
      arburst_d = '0;
    end
  end

  // AR channel and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q    <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      out0_q       <= 1'b0;
      out1_q       <= 1'b0;
      last_grant_q <= 1'b1;
      rid_err_q    <= 1'b0;
    end else begin
      arvalid_q    <= arvalid_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      last_grant_q <= last_grant_d;
      if (m_axi.RVALID & ~match0_c & ~match1_c) rid_err_q <= 1'b1;
    end
  end

  assign s0_arready_o = grant0_c;
  assign s1_arready_o = grant1_c;

  assign s0_rvalid_o = m_axi.RVALID & match0_c;
  assign s1_rvalid_o = m_axi.RVALID & match1_c;
  assign s0_rdata_o  = m_axi.RDATA;
  assign s1_rdata_o  = m_axi.RDATA;
  assign s0_rresp_o  = m_axi.RRESP;
  assign s1_rresp_o  = m_axi.RRESP;
  assign s0_rlast_o  = m_axi.RLAST;
  assign s1_rlast_o  = m_axi.RLAST;

  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARID    = arid_q;
  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARLEN   = arlen_q;
  assign m_axi.ARSIZE  = arsize_q;
  assign m_axi.ARBURST = arburst_q;
  assign m_axi.ARLOCK  = '0;
  assign m_axi.ARCACHE = '0;
  assign m_axi.ARPROT  = '0;
  assign m_axi.RREADY  = rready_c;
  assign rid_err_o     = rid_err_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: drives requesters and the AXI slave side
// one cycle at a time and compares against hand-computed values.
module tb_axi_read_arbiter;
  logic clk = 1'b0;
  logic reset, enable;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata;
  logic [7:0]  s0_arlen, s1_arlen;
  logic [2:0]  s0_arsize, s1_arsize;
  logic [1:0]  s0_arburst, s1_arburst, s0_rresp, s1_rresp;
  logic        rid_err;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter_if axi ();

  axi_read_arbiter #(.S0_ID(4'h0), .S1_ID(4'h1)) dut (
    .clk(clk), .reset(reset), .enable_i(enable),
    .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_araddr_i(s0_araddr),
    .s0_arlen_i(s0_arlen), .s0_arsize_i(s0_arsize), .s0_arburst_i(s0_arburst),
    .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready), .s0_rdata_o(s0_rdata),
    .s0_rresp_o(s0_rresp), .s0_rlast_o(s0_rlast),
    .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_araddr_i(s1_araddr),
    .s1_arlen_i(s1_arlen), .s1_arsize_i(s1_arsize), .s1_arburst_i(s1_arburst),
    .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready), .s1_rdata_o(s1_rdata),
    .s1_rresp_o(s1_rresp), .s1_rlast_o(s1_rlast),
    .m_axi(axi), .rid_err_o(rid_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    s0_arvalid = 1'b0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_rready = 1'b0;
    s1_arvalid = 1'b0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_rready = 1'b0;
    axi.ARREADY = 1'b0; axi.RID = '0; axi.RDATA = '0; axi.RRESP = '0; axi.RLAST = 1'b0; axi.RVALID = 1'b0;
    next(); next();

    // reset state
    check("rst_arvalid", 32'(axi.ARVALID), 0);
    check("rst_araddr", axi.ARADDR, 0);
    check("rst_arid_len", 32'({axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST}), 0);
    check("rst_const", 32'({axi.ARLOCK, axi.ARCACHE, axi.ARPROT}), 0);
    check("rst_arready", 32'({s0_arready, s1_arready}), 0);
    check("rst_rvalid", 32'({s0_rvalid, s1_rvalid}), 0);
    check("rst_rid_err", 32'(rid_err), 0);
    reset = 1'b0;

    // single request from s0, ARREADY on the third AR cycle
    s0_arvalid = 1'b1; s0_araddr = 32'hBFC0_0000; s0_arlen = 8'd0; s0_arsize = 3'd2; s0_arburst = 2'd1;
    #1;
    check("single_s0_arready", 32'(s0_arready), 1);
    check("single_s1_arready", 32'(s1_arready), 0);
    next();
    s0_arvalid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("single_arvalid", 32'(axi.ARVALID), 1);
      check("single_arid", 32'(axi.ARID), 0);
      check("single_araddr", axi.ARADDR, 32'hBFC0_0000);
      check("single_size_burst", 32'({axi.ARSIZE, axi.ARBURST}), 32'h9);
      check("single_no_regrant", 32'(s0_arready), 0);
      if (i == 2) axi.ARREADY = 1'b1;
      next();
    end
    axi.ARREADY = 1'b0;
    #1;
    check("single_arvalid_low", 32'(axi.ARVALID), 0);
    check("single_araddr_zero", axi.ARADDR, 0);
    axi.RVALID = 1'b1; axi.RID = 4'h0; axi.RDATA = 32'h1234_5678; axi.RLAST = 1'b1; s0_rready = 1'b1;
    #1;
    check("single_s0_rvalid", 32'(s0_rvalid), 1);
    check("single_s0_rdata", s0_rdata, 32'h1234_5678);
    check("single_s0_rlast", 32'(s0_rlast), 1);
    check("single_s1_rvalid", 32'(s1_rvalid), 0);
    check("single_rready", 32'(axi.RREADY), 1);
    next();
    axi.RVALID = 1'b0; s0_rready = 1'b0;
    enable = 1'b0; s0_arvalid = 1'b1;
    #1;
    check("enable_low_no_grant", 32'(s0_arready), 0);
    enable = 1'b1;
    #1;
    check("single_out0_cleared", 32'(s0_arready), 1);
    s0_arvalid = 1'b0;
    #1;

    // ties from reset: 0,1 then 0,1 again
    do_reset();
    axi.ARREADY = 1'b1;
    for (int r = 0; r < 2; r++) begin
      s0_arvalid = 1'b1; s1_arvalid = 1'b1;
      s0_araddr = 32'h1000_0000 + 32'(r); s1_araddr = 32'h2000_0000 + 32'(r);
      #1;
      check("tie_s0_first", 32'({s0_arready, s1_arready}), 32'h2);
      next();
      s0_arvalid = 1'b0;
      #1;
      check("tie_arid0", 32'({axi.ARVALID, axi.ARID}), 32'h10);
      check("tie_araddr0", axi.ARADDR, 32'h1000_0000 + 32'(r));
      check("tie_wait_no_grant", 32'(s1_arready), 0);
      next();
      check("tie_hs_low", 32'(axi.ARVALID), 0);
      check("tie_s1_second", 32'(s1_arready), 1);
      next();
      s1_arvalid = 1'b0;
      #1;
      check("tie_arid1", 32'({axi.ARVALID, axi.ARID}), 32'h11);
      check("tie_araddr1", axi.ARADDR, 32'h2000_0000 + 32'(r));
      next();
      check("tie_hs1_low", 32'(axi.ARVALID), 0);
      axi.RVALID = 1'b1; axi.RID = 4'h0; axi.RLAST = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
      next();
      axi.RID = 4'h1;
      next();
      axi.RVALID = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    end
    axi.ARREADY = 1'b0;

    // out-of-order return with backpressure on s1
    s0_arvalid = 1'b1; s0_araddr = 32'h3000_0000; s0_arlen = 8'd1;
    #1;
    check("ooo_grant0", 32'(s0_arready), 1);
    next();
    s0_arvalid = 1'b0; axi.ARREADY = 1'b1;
    next();
    axi.ARREADY = 1'b0;
    s1_arvalid = 1'b1; s1_araddr = 32'h4000_0000; s1_arlen = 8'd3;
    #1;
    check("ooo_grant1", 32'(s1_arready), 1);
    next();
    s1_arvalid = 1'b0; axi.ARREADY = 1'b1;
    #1;
    check("ooo_arid_len", 32'({axi.ARID, axi.ARLEN}), 32'h103);
    next();
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b1; axi.RID = 4'h1; axi.RLAST = 1'b0; axi.RDATA = 32'hA000_0000; s1_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rready_low", 32'(axi.RREADY), 0);
      check("bp_rvalid", 32'({s0_rvalid, s1_rvalid}), 32'h1);
      next();
    end
    s1_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      axi.RDATA = 32'hA000_0000 + 32'(b); axi.RLAST = (b == 3);
      if (b == 2) s1_arvalid = 1'b1;
      #1;
      check("ooo_s1_beat", 32'({s0_rvalid, s1_rvalid, axi.RREADY}), 32'h3);
      check("ooo_s1_rdata", s1_rdata, 32'hA000_0000 + 32'(b));
      if (b == 2) begin
        check("ooo_out1_held", 32'(s1_arready), 0);
        s1_arvalid = 1'b0;
      end
      next();
    end
    axi.RID = 4'h0; axi.RLAST = 1'b0; axi.RDATA = 32'hB000_0000; s0_rready = 1'b0;
    #1;
    check("ooo_s0_rready_low", 32'(axi.RREADY), 0);
    check("ooo_s0_route", 32'({s0_rvalid, s1_rvalid}), 32'h2);
    s0_rready = 1'b1;
    #1;
    check("ooo_s0_rready_high", 32'(axi.RREADY), 1);
    next();
    axi.RDATA = 32'hB000_0001; axi.RLAST = 1'b1;
    #1;
    check("ooo_s0_last", 32'({s0_rvalid, s0_rlast}), 32'h3);
    check("ooo_s0_rdata", s0_rdata, 32'hB000_0001);
    next();
    axi.RVALID = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    #1;
    check("ooo_both_clear_tie", 32'({s0_arready, s1_arready}), 32'h2);
    s0_arvalid = 1'b0;
    #1;
    check("ooo_out1_clear", 32'(s1_arready), 1);
    s1_arvalid = 1'b0;
    #1;

    // outstanding limit then stray ID
    s0_arvalid = 1'b1; s0_araddr = 32'h5000_0000; s0_arlen = 8'd0;
    #1;
    check("lim_grant", 32'(s0_arready), 1);
    next();
    axi.ARREADY = 1'b1;
    next();
    axi.ARREADY = 1'b0;
    #1;
    check("lim_blocked_a", 32'(s0_arready), 0);
    next();
    check("lim_blocked_b", 32'(s0_arready), 0);
    axi.RVALID = 1'b1; axi.RID = 4'h0; axi.RLAST = 1'b1; s0_rready = 1'b1;
    #1;
    check("lim_same_cycle", 32'({s0_rvalid, s0_arready}), 32'h2);
    next();
    axi.RVALID = 1'b0; s0_rready = 1'b0;
    #1;
    check("lim_regrant", 32'(s0_arready), 1);
    next();
    s0_arvalid = 1'b0; axi.ARREADY = 1'b1;
    next();
    axi.ARREADY = 1'b0;
    check("stray_pre", 32'(rid_err), 0);
    axi.RVALID = 1'b1; axi.RID = 4'h5; axi.RLAST = 1'b1;
    #1;
    check("stray_drain", 32'({axi.RREADY, s0_rvalid, s1_rvalid}), 32'h4);
    next();
    axi.RVALID = 1'b0;
    #1;
    check("stray_rid_err", 32'(rid_err), 1);
    next();
    check("stray_rid_err_held", 32'(rid_err), 1);

    // reset while in AR_WAIT with s1 outstanding
    s1_arvalid = 1'b1; s1_araddr = 32'h6000_0000; s1_arlen = 8'd7;
    #1;
    check("mid_grant", 32'(s1_arready), 1);
    next();
    s1_arvalid = 1'b0;
    #1;
    check("mid_ar_wait", 32'(axi.ARVALID), 1);
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    check("mid_rst_arvalid", 32'(axi.ARVALID), 0);
    check("mid_rst_araddr", axi.ARADDR, 0);
    check("mid_rst_fields", 32'({axi.ARID, axi.ARLEN}), 0);
    check("mid_rst_rid_err", 32'(rid_err), 0);
    s0_arvalid = 1'b1;
    #1;
    check("mid_rst_out0", 32'(s0_arready), 1);
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b1; s1_araddr = 32'h7000_0000;
    #1;
    check("mid_rst_out1", 32'(s1_arready), 1);
    next();
    s1_arvalid = 1'b0;
    #1;
    check("mid_fresh_ar", 32'({axi.ARVALID, axi.ARID}), 32'h11);
    check("mid_fresh_addr", axi.ARADDR, 32'h7000_0000);
    axi.ARREADY = 1'b1;
    next();
    axi.ARREADY = 1'b0;
    #1;
    check("mid_fresh_done", 32'(axi.ARVALID), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-requester arbiter that shares a single AXI read master port between the instruction-side and data-side read interfaces. It accepts AR requests from each requester under round-robin arbitration and drives one registered AR channel toward the AXI interconnect. It tags each request with a per-requester ARID and routes R beats back by RID. It sits between the inst/data RAM interfaces and the top-level AXI bridge.

## Interface
- S0_ID, 4'h0, ARID assigned to requester 0 (instruction side)
- S1_ID, 4'h1, ARID assigned to requester 1 (data side); must differ from S0_ID
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  when low, no new grant; in-flight AR/R handshakes continue
- sN_arvalid  in  1  requester N (N=0,1) read request
- sN_arready  out  1  grant/accept pulse to requester N
- sN_araddr  in  32  request address
- sN_arlen  in  8  burst length minus 1
- sN_arsize  in  3  beat size
- sN_arburst  in  2  burst type
- sN_rvalid  out  1  routed R beat valid
- sN_rready  in  1  requester N ready for R beat
- sN_rdata  out  32  routed RDATA
- sN_rresp  out  2  routed RRESP
- sN_rlast  out  1  routed RLAST
- ARID  out  4, ARADDR  out  32, ARLEN  out  8, ARSIZE  out  3, ARBURST  out  2 — registered AR fields
- ARLOCK  out  2, ARCACHE  out  4, ARPROT  out  3 — constant 0
- ARVALID  out  1, ARREADY  in  1
- RID  in  4, RDATA  in  32, RRESP  in  2, RLAST  in  1, RVALID  in  1, RREADY  out  1
- rid_err  out  1  sticky: an R beat arrived with no matching outstanding ID

## Operation
- AR state machine: IDLE, AR_WAIT.
- IDLE: eligible_N = sN_arvalid & ~outN & enable.
  - One eligible requester: it is granted.
  - Both eligible: the requester other than last_grant is granted.
  - sN_arready = IDLE & granted (combinational, 1 cycle).
  - At the grant edge: latch ARADDR/ARLEN/ARSIZE/ARBURST from requester N and ARID = SN_ID; set ARVALID=1, outN=1, last_grant=N; go to AR_WAIT.
- AR_WAIT: hold all AR fields stable while ARVALID=1. On ARVALID & ARREADY: clear ARVALID, zero AR fields, go to IDLE. No grant is issued in AR_WAIT.
- outN: at most one outstanding burst per requester, two total. Set at grant. Cleared on the edge with RVALID & RREADY & RLAST & RID==SN_ID & outN.
- R routing (combinational):
  - match0 = RID==S0_ID & out0; match1 = RID==S1_ID & out1.
  - sN_rvalid = RVALID & matchN. sN_rdata, sN_rresp and sN_rlast mirror the AXI R fields to both requesters.
  - RREADY = match0 ? s0_rready : match1 ? s1_rready : 1.
  - Unmatched beats are drained with RREADY=1; rid_err is set on such a beat with RVALID=1 and stays set until reset.
- Out-of-order completion between the two IDs is permitted and handled.

## Timing
- Reset values:
  - ARVALID=0, ARID/ARADDR/ARLEN/ARSIZE/ARBURST=0, ARLOCK/ARCACHE/ARPROT=0.
  - out0=out1=0, last_grant=1 (requester 0 wins the first tie), state IDLE, rid_err=0.
  - sN_arready=0 and sN_rvalid=0 follow combinationally.
- Grant at edge E: ARVALID is high from cycle E+1. Handshake at edge H: ARVALID is low from H+1. The next grant is earliest at edge H+1, so AR issue rate is one per 2 cycles minimum.
- R path adds zero latency. RREADY depends combinationally on RID/RVALID state and the matched sN_rready.
- outN is evaluated as a registered value. When requester N's last beat completes in the same cycle it re-requests, no grant is given that cycle; the grant comes at the next edge.
- ARREADY stuck low: AR_WAIT holds indefinitely, and the other requester is starved. This is by design.
- enable low in AR_WAIT: the handshake still completes. enable low in IDLE: no grant.
- Reset mid-burst: all state cleared and in-flight AXI transactions abandoned. The AXI slave must be reset in the same cycle.

## Test plan
- Single request: s0 request, addr 0xBFC0_0000, arlen 0; ARREADY after 2 cycles; RID=0, RDATA 0x1234_5678, RLAST=1 -> ARID=0, ARADDR=0xBFC0_0000 held 3 cycles; s0_rvalid pulses with rdata 0x1234_5678; out0 cleared; s1_rvalid stays 0.
- Tie arbitration: s0 and s1 request in the same cycle from reset, ARREADY always 1 -> s0 granted first and s1 second (ARID 0 then 1, 2 cycles apart). Repeated ties alternate 0,1,0,1.
- Out-of-order return: grant s0 then s1; R returns RID=1 first (arlen 3, 4 beats), then RID=0 -> beats routed only to s1, then s0; RREADY follows the matched rready; both out bits clear after their RLAST.
- Backpressure: s1 burst with s1_rready low for 3 cycles while RVALID=1 -> RREADY=0 for those cycles and no beat is lost; data is accepted when s1_rready rises.
- Outstanding limit and stray ID: with out0=1, s0 asserts arvalid -> no s0_arready until s0's RLAST completes, then a grant one cycle later. A beat with RID=4'h5 -> RREADY=1, no sN_rvalid, rid_err=1 and held.
- Reset mid-operation: assert reset while in AR_WAIT with out1=1 -> next cycle ARVALID=0, AR fields 0, out bits 0, rid_err 0; a fresh s1 request is granted normally.
